// File: rtl/pipelined_cla_addsub_if.sv
// rtl/pipelined_cla_addsub_if.sv - operand/result handshake bundle for pipelined_cla_addsub
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             V;
  logic             Z;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output A, B, Cin, Sub, in_valid, out_ready,
    input  in_ready, Sum, Cout, V, Z, out_valid
  );

  modport slave (
    input  A, B, Cin, Sub, in_valid, out_ready,
    output in_ready, Sum, Cout, V, Z, out_valid
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined two-level carry-lookahead adder/subtractor
// One STAGE_BITS slice is resolved per stage; the slice carry is registered between stages.
module pipelined_cla_addsub #(
  parameter int WIDTH      = 32,
  parameter int STAGE_BITS = 16,
  parameter int GROUP      = 4
) (
  input logic                   Clk,
  input logic                   Reset,
  pipelined_cla_addsub_if.slave io
);
  localparam int N  = WIDTH / STAGE_BITS;
  localparam int SB = STAGE_BITS;
  localparam int NG = STAGE_BITS / GROUP;

  // Returns {carry_out, sum}; group carries are the flattened GG/PG sum of products.
  function automatic logic [SB:0] cla_slice(input logic [SB-1:0] a, input logic [SB-1:0] b,
                                            input logic cin);
    logic [SB-1:0] g, p, s;
    logic [NG-1:0] gg, pg;
    logic [NG:0]   gc;
    logic          term, c;
    g = a & b;
    p = a ^ b;
    for (int i = 0; i < NG; i++) begin
      gg[i] = 1'b0;
      pg[i] = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        gg[i] = g[i*GROUP+j] | (p[i*GROUP+j] & gg[i]);
        pg[i] = pg[i] & p[i*GROUP+j];
      end
    end
    gc[0] = cin;
    for (int i = 1; i <= NG; i++) begin
      term = cin;
      for (int m = 0; m < i; m++) term = term & pg[m];
      gc[i] = term;
      for (int j = 0; j < i; j++) begin
        term = gg[j];
        for (int m = j + 1; m < i; m++) term = term & pg[m];
        gc[i] = gc[i] | term;
      end
    end
    for (int i = 0; i < NG; i++) begin
      c = gc[i];
      for (int j = 0; j < GROUP; j++) begin
        s[i*GROUP+j] = p[i*GROUP+j] ^ c;
        c = g[i*GROUP+j] | (p[i*GROUP+j] & c);
      end
    end
    return {gc[NG], s};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] bx0;
  logic             c0;
  logic             out_valid_r, cout_r, v_r, z_r;
  logic [WIDTH-1:0] sum_r;

  assign adv          = !out_valid_r || io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_r;
  assign io.Sum       = sum_r;
  assign io.Cout      = cout_r;
  assign io.V         = v_r;
  assign io.Z         = z_r;

  assign bx0 = io.Sub ? ~io.B : io.B;
  assign c0  = io.Sub ? ~io.Cin : io.Cin;

  logic [SB-1:0]    fa, fbx;
  logic             fc, fv;
  logic [SB:0]      fr;
  logic [WIDTH-1:0] fsum;

  generate
    // Stage k keeps only the still-pending upper operand bits and the finished low sum bits.
    for (genvar k = 0; k < N - 1; k++) begin : g_stage
      localparam int WI = WIDTH - k * SB;
      localparam int WR = WI - SB;
      localparam int WS = (k + 1) * SB;

      logic [WI-1:0] a_i, bx_i;
      logic          c_i, v_i;
      logic [SB:0]   r;
      logic [WS-1:0] sum_d;
      logic [WR-1:0] a_q, bx_q;
      logic [WS-1:0] sum_q;
      logic          c_q, v_q;

      if (k == 0) begin : g_head
        assign a_i   = io.A;
        assign bx_i  = bx0;
        assign c_i   = c0;
        assign v_i   = io.in_valid;
        assign sum_d = r[SB-1:0];
      end else begin : g_body
        assign a_i   = g_stage[k-1].a_q;
        assign bx_i  = g_stage[k-1].bx_q;
        assign c_i   = g_stage[k-1].c_q;
        assign v_i   = g_stage[k-1].v_q;
        assign sum_d = {r[SB-1:0], g_stage[k-1].sum_q};
      end

      assign r = cla_slice(a_i[SB-1:0], bx_i[SB-1:0], c_i);

      always_ff @(posedge Clk) begin
        if (Reset) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q <= v_i;
          if (v_i) begin
            a_q   <= a_i[WI-1:SB];
            bx_q  <= bx_i[WI-1:SB];
            sum_q <= sum_d;
            c_q   <= r[SB];
          end
        end
      end
    end

    if (N == 1) begin : g_single
      assign fa   = io.A[SB-1:0];
      assign fbx  = bx0[SB-1:0];
      assign fc   = c0;
      assign fv   = io.in_valid;
      assign fsum = fr[SB-1:0];
    end else begin : g_multi
      assign fa   = g_stage[N-2].a_q;
      assign fbx  = g_stage[N-2].bx_q;
      assign fc   = g_stage[N-2].c_q;
      assign fv   = g_stage[N-2].v_q;
      assign fsum = {fr[SB-1:0], g_stage[N-2].sum_q};
    end
  endgenerate

  assign fr = cla_slice(fa, fbx, fc);

  // Output register doubles as the last pipeline stage; flags are taken from its operands.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      v_r         <= 1'b0;
      z_r         <= 1'b0;
    end else if (adv) begin
      out_valid_r <= fv;
      if (fv) begin
        sum_r  <= fsum;
        cout_r <= fr[SB];
        v_r    <= (fa[SB-1] == fbx[SB-1]) && (fr[SB-1] != fa[SB-1]);
        z_r    <= ~|fsum;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - directed and randomized scoreboard bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   rnd_go = 1'b0;
  int   rnd_done = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  pipelined_cla_addsub_if #(.WIDTH(32)) dio();
  pipelined_cla_addsub #(.WIDTH(32), .STAGE_BITS(16), .GROUP(4)) dut_d (
    .Clk(clk), .Reset(rst), .io(dio)
  );

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    dio.A = a; dio.B = b; dio.Cin = cin; dio.Sub = sub; dio.in_valid = 1'b1;
  endtask

  task automatic dop(input string nm, input logic [31:0] a, input logic [31:0] b, input logic cin,
                     input logic sub, input logic [31:0] es, input logic ec, input logic ev,
                     input logic ez);
    @(negedge clk);
    drive(a, b, cin, sub);
    #1 check({nm, "_in_ready"}, dio.in_ready, 1);
    @(posedge clk);
    #1 dio.in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_latency"}, dio.out_valid, 0);
    @(negedge clk);
    check({nm, "_out_valid"}, dio.out_valid, 1);
    check({nm, "_sum"}, dio.Sum, es);
    check({nm, "_cout"}, dio.Cout, ec);
    check({nm, "_v"}, dio.V, ev);
    check({nm, "_z"}, dio.Z, ez);
    @(negedge clk);
    check({nm, "_single"}, dio.out_valid, 0);
  endtask

  // Random regression at N=2, 4 and 1 against an arithmetic scoreboard.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int W  = (gi == 0) ? 32 : ((gi == 1) ? 64 : 16);
    localparam int NS = W / 16;

    pipelined_cla_addsub_if #(.WIDTH(W)) rio();
    pipelined_cla_addsub #(.WIDTH(W), .STAGE_BITS(16), .GROUP(4)) dut (
      .Clk(clk), .Reset(rst), .io(rio)
    );

    logic [W-1:0] q_sum[$];
    logic [2:0]   q_flg[$];
    int           q_stamp[$];
    int           adv_cnt;

    initial begin
      logic [63:0]  t;
      logic [W-1:0] a, b, bx, es;
      logic [W:0]   full;
      logic         cz, adv_now, exp_ov;
      rio.A = '0; rio.B = '0; rio.Cin = 1'b0; rio.Sub = 1'b0;
      rio.in_valid = 1'b0; rio.out_ready = 1'b0;
      adv_cnt = 0;
      wait (rnd_go);
      for (int cyc = 0; cyc < 10008; cyc++) begin
        @(negedge clk);
        if (cyc < 10000) begin
          t = {$urandom, $urandom};
          case ($urandom_range(0, 7))
            0: a = '1;
            1: a = '0;
            default: a = t[W-1:0];
          endcase
          t = {$urandom, $urandom};
          case ($urandom_range(0, 7))
            0: b = '0;
            1: b = {{(W-1){1'b0}}, 1'b1};
            2: b = a;
            default: b = t[W-1:0];
          endcase
          rio.A = a; rio.B = b;
          rio.Cin = 1'($urandom_range(0, 1));
          rio.Sub = 1'($urandom_range(0, 1));
          rio.in_valid = ($urandom_range(0, 3) != 0);
          rio.out_ready = ($urandom_range(0, 3) != 0);
        end else begin
          rio.in_valid = 1'b0;
          rio.out_ready = 1'b1;
        end
        #1;
        exp_ov = (q_sum.size() != 0) && (adv_cnt - q_stamp[0] >= NS - 1);
        check($sformatf("rnd%0d_out_valid", W), rio.out_valid, exp_ov);
        if (rio.out_valid && q_sum.size() != 0) begin
          check($sformatf("rnd%0d_sum", W), rio.Sum, q_sum[0]);
          check($sformatf("rnd%0d_flags", W), {rio.Cout, rio.V, rio.Z}, q_flg[0]);
        end
        adv_now = !exp_ov || rio.out_ready;
        check($sformatf("rnd%0d_in_ready", W), rio.in_ready, adv_now);
        if (exp_ov && rio.out_ready) begin
          void'(q_sum.pop_front());
          void'(q_flg.pop_front());
          void'(q_stamp.pop_front());
        end
        if (rio.in_valid && adv_now) begin
          bx   = rio.Sub ? ~rio.B : rio.B;
          cz   = rio.Sub ? ~rio.Cin : rio.Cin;
          full = {1'b0, rio.A} + {1'b0, bx} + {{W{1'b0}}, cz};
          es   = full[W-1:0];
          q_sum.push_back(es);
          q_flg.push_back({full[W], (rio.A[W-1] == bx[W-1]) && (es[W-1] != rio.A[W-1]), es == '0});
          q_stamp.push_back(adv_cnt + 1);
        end
        if (adv_now) adv_cnt++;
      end
      check($sformatf("rnd%0d_drained", W), q_sum.size(), 0);
      rnd_done++;
    end
  end

  initial begin
    rst = 1'b1;
    dio.A = '0; dio.B = '0; dio.Cin = 1'b0; dio.Sub = 1'b0;
    dio.in_valid = 1'b0; dio.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    check("rst_out_valid", dio.out_valid, 0);
    check("rst_sum", dio.Sum, 0);
    check("rst_cout", dio.Cout, 0);
    check("rst_v", dio.V, 0);
    check("rst_z", dio.Z, 0);
    check("rst_in_ready", dio.in_ready, 1);

    dop("xslice", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    dop("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    dop("sovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    dop("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    dop("sub_borrow", 32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

    @(negedge clk); drive(32'd1, 32'd1, 1'b0, 1'b0);
    @(negedge clk); drive(32'd2, 32'd2, 1'b0, 1'b0);
    @(negedge clk); dio.out_ready = 1'b0; drive(32'd3, 32'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check("bp_in_ready", dio.in_ready, 0);
      check("bp_out_valid", dio.out_valid, 1);
      check("bp_hold_sum", dio.Sum, 32'd2);
    end
    @(negedge clk); dio.out_ready = 1'b1;
    #1;
    check("bp_release_ready", dio.in_ready, 1);
    check("bp_first", dio.Sum, 32'd2);
    @(posedge clk);
    #1 dio.in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", dio.out_valid, 1);
    check("bp_second", dio.Sum, 32'd4);
    @(negedge clk);
    check("bp_third_valid", dio.out_valid, 1);
    check("bp_third", dio.Sum, 32'd6);
    @(negedge clk);
    check("bp_empty", dio.out_valid, 0);

    @(negedge clk); dio.out_ready = 1'b0; drive(32'h10, 32'h10, 1'b0, 1'b0);
    @(negedge clk); drive(32'h20, 32'h20, 1'b0, 1'b0);
    @(negedge clk); dio.in_valid = 1'b0; rst = 1'b1;
    #1 check("mid_pre_valid", dio.out_valid, 1);
    @(negedge clk); rst = 1'b0;
    #1;
    check("mid_out_valid", dio.out_valid, 0);
    check("mid_sum", dio.Sum, 0);
    check("mid_cout", dio.Cout, 0);
    check("mid_v", dio.V, 0);
    check("mid_z", dio.Z, 0);
    check("mid_in_ready", dio.in_ready, 1);
    dio.out_ready = 1'b1;
    dop("post_rst", 32'h00001234, 32'h00001111, 1'b0, 1'b0, 32'h00002345, 1'b0, 1'b0, 1'b0);

    rnd_go = 1'b1;
    for (int i = 0; i < 30000 && rnd_done < 3; i++) @(posedge clk);
    check("rnd_complete", rnd_done, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
